// File: rtl/seq_detect_arbiter.sv
// Multi-channel overlapping "101" detector sharing one Mealy engine through a round-robin grant.
// Optional per-channel saturating match counters: define SEQ_DET_MATCH_COUNT_EN.

module seq_detect_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             take,
    input  logic             din,
    input  logic             clr,
    output logic             hit
`ifdef SEQ_DET_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } st_t;

    st_t st, st_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= S0;
        else       st <= st_nxt;
    end

    // Clear wins; otherwise the entry only moves when this lane owns the engine.
    always_comb begin
        st_nxt = st;
        hit    = 1'b0;
        if (clr) begin
            st_nxt = S0;
        end else if (take) begin
            case (st)
                S0: st_nxt = din ? S1 : S0;
                S1: st_nxt = din ? S1 : S2;
                S2: begin
                    st_nxt = din ? S1 : S0;
                    hit    = din;
                end
                default: st_nxt = S0;
            endcase
        end
    end

`ifdef SEQ_DET_MATCH_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  count <= '0;
        else if (clr)               count <= '0;
        else if (hit && count != '1) count <= count + 1'b1;
    end
`endif

endmodule

module seq_detect_arbiter #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    parameter int CH_W  = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  ch_valid,
    input  logic [N_CH-1:0]  ch_bit,
    input  logic [N_CH-1:0]  ch_clr,
    output logic [N_CH-1:0]  ch_ready,
    output logic             match_valid,
    output logic [CH_W-1:0]  match_ch
`ifdef SEQ_DET_MATCH_COUNT_EN
    ,
    input  logic [CH_W-1:0]  rd_sel,
    output logic [CNT_W-1:0] rd_count
`endif
);

    logic [N_CH-1:0] elig, take, hit;
    logic [CH_W-1:0] rr_ptr, gnt_idx, ptr_nxt;
    logic            gnt_any;

    // A channel being cleared is not eligible, so its source never sees a consumed bit.
    assign elig = ch_valid & ~ch_clr;

    always_comb begin
        ch_ready = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            logic [CH_W:0] idx;
            idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(N_CH)) idx = idx - (CH_W+1)'(N_CH);
            if (!gnt_any && elig[idx[CH_W-1:0]]) begin
                gnt_any                  = 1'b1;
                gnt_idx                  = idx[CH_W-1:0];
                ch_ready[idx[CH_W-1:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_nxt = rr_ptr;
        if (gnt_any)
            ptr_nxt = ({1'b0, gnt_idx} == (CH_W+1)'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign take = ch_valid & ch_ready;

`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [N_CH-1:0][CNT_W-1:0] counts;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        seq_detect_lane #(.CNT_W(CNT_W)) u_lane (
            .clk   (clk),
            .reset (reset),
            .take  (take[k]),
            .din   (ch_bit[k]),
            .clr   (ch_clr[k]),
            .hit   (hit[k])
`ifdef SEQ_DET_MATCH_COUNT_EN
            ,
            .count (counts[k])
`endif
        );
    end

    // At most one lane is granted, so at most one hit bit is set and gnt_idx names it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            match_valid <= 1'b0;
            match_ch    <= '0;
        end else begin
            rr_ptr      <= ptr_nxt;
            match_valid <= |hit;
            if (|hit) match_ch <= gnt_idx;
        end
    end

`ifdef SEQ_DET_MATCH_COUNT_EN
    always_comb begin
        rd_count = '0;
        if ({1'b0, rd_sel} < (CH_W+1)'(N_CH)) rd_count = counts[rd_sel];
    end
`endif

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed table-driven bench for seq_detect_arbiter (4 channels, 2-bit counters).
`timescale 1ns/1ps

module tb_seq_detect_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ch_valid, ch_bit, ch_clr, ch_ready;
    logic       match_valid;
    logic [1:0] match_ch;
`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [1:0] rd_sel;
    logic [1:0] rd_count;
`endif

    int checks = 0;
    int errors = 0;

    seq_detect_arbiter #(.N_CH(4), .CNT_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_valid    (ch_valid),
        .ch_bit      (ch_bit),
        .ch_clr      (ch_clr),
        .ch_ready    (ch_ready),
        .match_valid (match_valid),
        .match_ch    (match_ch)
`ifdef SEQ_DET_MATCH_COUNT_EN
        ,
        .rd_sel      (rd_sel),
        .rd_count    (rd_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v, b, c, rdy;
        logic       mv;
        logic [1:0] mch;
    } vec_t;

    vec_t tbl[43];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [3:0] v, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] rdy, input logic mv, input logic [1:0] mch);
        tbl[i].v = v; tbl[i].b = b; tbl[i].c = c;
        tbl[i].rdy = rdy; tbl[i].mv = mv; tbl[i].mch = mch;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
        @(negedge clk);
        ch_valid = v; ch_bit = b; ch_clr = c;
        #1;
    endtask

    int mcount;

    initial begin
        reset = 1'b1; ch_valid = '0; ch_bit = '0; ch_clr = '0;
`ifdef SEQ_DET_MATCH_COUNT_EN
        rd_sel = '0;
`endif
        // single channel 0: 1,0,1,0,1
        setv(0, 4'h1, 4'h1, 4'h0, 4'h1, 0, 0);
        setv(1, 4'h1, 4'h0, 4'h0, 4'h1, 0, 0);
        setv(2, 4'h1, 4'h1, 4'h0, 4'h1, 0, 0);
        setv(3, 4'h1, 4'h0, 4'h0, 4'h1, 1, 0);
        setv(4, 4'h1, 4'h1, 4'h0, 4'h1, 0, 0);
        setv(5, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0);
        setv(6, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
        setv(7, 4'h0, 4'h0, 4'h1, 4'h0, 0, 0);
        // channels 0 and 2 alternate; only ch0 (1,0,1) matches
        setv(8,  4'h5, 4'h4, 4'h0, 4'h4, 0, 0);
        setv(9,  4'h5, 4'h5, 4'h0, 4'h1, 0, 0);
        setv(10, 4'h5, 4'h4, 4'h0, 4'h4, 0, 0);
        setv(11, 4'h5, 4'h4, 4'h0, 4'h1, 0, 0);
        setv(12, 4'h5, 4'h5, 4'h0, 4'h4, 0, 0);
        setv(13, 4'h5, 4'h5, 4'h0, 4'h1, 0, 0);
        setv(14, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0);
        // all four valid, then drop ch1
        setv(15, 4'hF, 4'h0, 4'h0, 4'h2, 0, 0);
        setv(16, 4'hF, 4'h0, 4'h0, 4'h4, 0, 0);
        setv(17, 4'hF, 4'h0, 4'h0, 4'h8, 0, 0);
        setv(18, 4'hF, 4'h0, 4'h0, 4'h1, 0, 0);
        setv(19, 4'hF, 4'h0, 4'h0, 4'h2, 0, 0);
        setv(20, 4'hD, 4'h0, 4'h0, 4'h4, 0, 0);
        setv(21, 4'hD, 4'h0, 4'h0, 4'h8, 0, 0);
        setv(22, 4'hD, 4'h0, 4'h0, 4'h1, 0, 0);
        setv(23, 4'hD, 4'h0, 4'h0, 4'h4, 0, 0);
        setv(24, 4'hD, 4'h0, 4'h0, 4'h8, 0, 0);
        // ch1 1,0 then clear while valid, then 1: no match
        setv(25, 4'h2, 4'h2, 4'h0, 4'h2, 0, 0);
        setv(26, 4'h2, 4'h0, 4'h0, 4'h2, 0, 0);
        setv(27, 4'h2, 4'h2, 4'h2, 4'h0, 0, 0);
        setv(28, 4'h2, 4'h2, 4'h0, 4'h2, 0, 0);
        setv(29, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
        // ch3 match, match_ch holds afterwards
        setv(30, 4'h8, 4'h8, 4'h0, 4'h8, 0, 0);
        setv(31, 4'h8, 4'h0, 4'h0, 4'h8, 0, 0);
        setv(32, 4'h8, 4'h8, 4'h0, 4'h8, 0, 0);
        setv(33, 4'h0, 4'h0, 4'h0, 4'h0, 1, 3);
        setv(34, 4'h0, 4'h0, 4'h0, 4'h0, 0, 3);
        // back-to-back matches on ch0 then ch2
        setv(35, 4'h5, 4'h5, 4'h0, 4'h1, 0, 3);
        setv(36, 4'h5, 4'h5, 4'h0, 4'h4, 0, 3);
        setv(37, 4'h5, 4'h0, 4'h0, 4'h1, 0, 3);
        setv(38, 4'h5, 4'h0, 4'h0, 4'h4, 0, 3);
        setv(39, 4'h5, 4'h5, 4'h0, 4'h1, 0, 3);
        setv(40, 4'h5, 4'h5, 4'h0, 4'h4, 1, 0);
        setv(41, 4'h0, 4'h0, 4'h0, 4'h0, 1, 2);
        setv(42, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2);

        // ready is combinational even while reset is held
        drive(4'h4, 4'h0, 4'h0);
        chk("ready_in_reset", ch_ready, 4'h4);
        drive(4'h0, 4'h0, 4'h0);
        chk("reset_mv", match_valid, 0);
        chk("reset_mch", match_ch, 0);
        reset = 1'b0;

        for (int i = 0; i < 43; i++) begin
            drive(tbl[i].v, tbl[i].b, tbl[i].c);
            chk($sformatf("v%0d_ready", i), ch_ready, tbl[i].rdy);
            chk($sformatf("v%0d_mv", i), match_valid, tbl[i].mv);
            chk($sformatf("v%0d_mch", i), match_ch, tbl[i].mch);
        end

`ifdef SEQ_DET_MATCH_COUNT_EN
        begin
            int exp_cnt[4] = '{2, 0, 1, 1};
            for (int k = 0; k < 4; k++) begin
                @(negedge clk); rd_sel = 2'(k); #1;
                chk($sformatf("count_ch%0d", k), rd_count, exp_cnt[k]);
            end
        end
`endif

        // saturation: 13 bits 1010101010101 on ch0 -> 6 matches, 2-bit counter stops at 3
        drive(4'h0, 4'h0, 4'h1);
        mcount = 0;
        for (int i = 0; i < 13; i++) begin
            drive(4'h1, {3'b0, (i % 2 == 0)}, 4'h0);
            if (match_valid) mcount++;
        end
        drive(4'h0, 4'h0, 4'h0);
        if (match_valid) mcount++;
        chk("sat_matches", mcount, 6);
`ifdef SEQ_DET_MATCH_COUNT_EN
        rd_sel = 2'd0; #1;
        chk("sat_count", rd_count, 3);
`endif

        // one-cycle reset after ch3 saw 1,0: partial pattern discarded, pointer back at 0
        drive(4'h8, 4'h8, 4'h0);
        drive(4'h8, 4'h0, 4'h0);
        @(negedge clk); ch_valid = '0; reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        chk("rst_mv", match_valid, 0);
        chk("rst_mch", match_ch, 0);
`ifdef SEQ_DET_MATCH_COUNT_EN
        chk("rst_count", rd_count, 0);
`endif
        drive(4'hF, 4'h0, 4'h0);
        chk("rst_ptr", ch_ready, 4'h1);
        drive(4'h8, 4'h8, 4'h0);
        chk("rst_ch3_ready", ch_ready, 4'h8);
        drive(4'h0, 4'h0, 4'h0);
        chk("rst_nomatch", match_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
